div_unit: RTL and testbench

Multicycle signed integer divider for the MIPS datapath, implementing DIV. It responds to the control unit's divide request and computes quotient (LO) and remainder (HI) by iterative restoring division. It reports completion to the control unit with a done pulse, and raises a divide-by-zero exception flag instead of computing. Outputs feed the HIdiv/LOdiv registers.

---
 rtl/div_unit.sv | 129 ++++++++++++
 tb/tb_div_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multicycle signed divider (restoring, one quotient bit per clock) for the MIPS DIV path.
// Quotient truncates toward zero; the remainder takes the sign of the dividend.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH:0]   dvsr_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quot_q;
    logic [CW-1:0]    cnt_q;
    logic             neg_quot_q;
    logic             neg_rem_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;
    logic             div0_q;

    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quot_d;

    // Magnitudes are taken as unsigned, so |-2^(WIDTH-1)| is exact.
    always_comb begin
        dvd_abs = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
        dvs_abs = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
    end

    // One restoring step: shift {rem,quot} left, try to subtract the divisor.
    always_comb begin
        rem_sh = {rem_q, quot_q[WIDTH-1]};
        trial  = rem_sh - dvsr_q;
        rem_d  = rem_sh[WIDTH-1:0];
        quot_d = {quot_q[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            rem_d  = trial[WIDTH-1:0];
            quot_d = {quot_q[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            dvsr_q     <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            cnt_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div0_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            div0_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (div_start) begin
                        if (divisor == '0) begin
                            div0_q <= 1'b1;
                        end else begin
                            dvsr_q     <= {1'b0, dvs_abs};
                            quot_q     <= dvd_abs;
                            rem_q      <= '0;
                            cnt_q      <= '0;
                            neg_rem_q  <= dividend[WIDTH-1];
                            neg_quot_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            busy_q     <= 1'b1;
                            state_q    <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q  <= rem_d;
                    quot_q <= quot_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    lo_q    <= neg_quot_q ? (~quot_q + 1'b1) : quot_q;
                    hi_q    <= neg_rem_q  ? (~rem_q + 1'b1)  : rem_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign hi        = hi_q;
    assign lo        = lo_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign div0      = div0_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed quotient/remainder, latency, div0 and reset cases.
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        div_start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div0;
    logic [1:0]  dbg_state;

    int checks;
    int failures;
    int m;
    int pulses;

    div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .div_start (div_start),
        .dividend  (dividend),
        .divisor   (divisor),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done),
        .div0      (div0),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a start request at a negedge; returns at the negedge after the accepting edge.
    task automatic start_div(input logic [31:0] a, input logic [31:0] b);
        dividend  = a;
        divisor   = b;
        div_start = 1'b1;
        @(negedge clk);
        div_start = 1'b0;
    endtask

    // Count clock edges since the accepting edge until done is seen (bounded).
    task automatic wait_done(input int m0, output int mo);
        mo = m0;
        while (!done && mo < 60) begin
            if (mo == 32) check("busy_last_calc", {31'b0, busy}, 32'd1);
            @(negedge clk);
            mo++;
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        div_start = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_div0", {31'b0, div0}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 7 / 2
        start_div(32'd7, 32'd2);
        check("7_2_busy0", {31'b0, busy}, 32'd1);
        wait_done(0, m);
        check("7_2_latency", m, 32'd33);
        check("7_2_lo", lo, 32'd3);
        check("7_2_hi", hi, 32'd1);
        check("7_2_busy_done", {31'b0, busy}, 32'd0);
        @(negedge clk);
        check("7_2_done_pulse", {31'b0, done}, 32'd0);

        // Divide by zero: flag pulse only, results held
        start_div(32'd5, 32'd0);
        check("div0_pulse", {31'b0, div0}, 32'd1);
        check("div0_busy", {31'b0, busy}, 32'd0);
        check("div0_done", {31'b0, done}, 32'd0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || div0) pulses++;
        end
        check("div0_no_more_pulses", pulses, 32'd0);
        check("div0_hi_held", hi, 32'd1);
        check("div0_lo_held", lo, 32'd3);

        // -7 / 2
        start_div(32'hFFFF_FFF9, 32'd2);
        wait_done(0, m);
        check("m7_2_latency", m, 32'd33);
        check("m7_2_lo", lo, 32'hFFFF_FFFD);
        check("m7_2_hi", hi, 32'hFFFF_FFFF);
        @(negedge clk);

        // 7 / -2
        start_div(32'd7, 32'hFFFF_FFFE);
        wait_done(0, m);
        check("7_m2_lo", lo, 32'hFFFF_FFFD);
        check("7_m2_hi", hi, 32'd1);
        @(negedge clk);

        // Overflow -2^31 / -1 wraps, no exception
        start_div(32'h8000_0000, 32'hFFFF_FFFF);
        pulses = 0;
        m = 0;
        while (!done && m < 60) begin
            if (div0) pulses++;
            @(negedge clk);
            m++;
        end
        check("ovf_latency", m, 32'd33);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'd0);
        check("ovf_no_div0", pulses, 32'd0);
        @(negedge clk);

        // -2^31 / 1
        start_div(32'h8000_0000, 32'd1);
        wait_done(0, m);
        check("min_1_lo", lo, 32'h8000_0000);
        check("min_1_hi", hi, 32'd0);
        @(negedge clk);

        // 100 / 7 with a second start (50/3) ignored at cycle 10
        start_div(32'd100, 32'd7);
        repeat (9) @(negedge clk);
        dividend  = 32'd50;
        divisor   = 32'd3;
        div_start = 1'b1;
        @(negedge clk);
        div_start = 1'b0;
        dividend  = 32'hDEAD_BEEF;
        divisor   = 32'd0;
        check("restart_busy", {31'b0, busy}, 32'd1);
        wait_done(10, m);
        check("100_7_latency", m, 32'd33);
        check("100_7_lo", lo, 32'd14);
        check("100_7_hi", hi, 32'd2);

        // Start accepted in the done cycle: 9 / 3
        start_div(32'd9, 32'd3);
        check("b2b_done_clear", {31'b0, done}, 32'd0);
        check("b2b_busy", {31'b0, busy}, 32'd1);
        wait_done(0, m);
        check("9_3_latency", m, 32'd33);
        check("9_3_lo", lo, 32'd3);
        check("9_3_hi", hi, 32'd0);
        @(negedge clk);

        // Reset mid-division aborts asynchronously
        start_div(32'd100, 32'd7);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        #1;
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        check("arst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || div0) pulses++;
        end
        check("arst_no_pulse", pulses, 32'd0);
        check("arst_idle_busy", {31'b0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
